hazard_forwarding_unit: RTL

HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

---
 rtl/hazard_forwarding_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hazard_forwarding_unit.sv
// Operand forwarding from FWD_STAGES downstream stages plus a load-use stall FSM.
// Build with HAZARD_STATS_EN defined to get the stall/forward statistics counters.
`ifndef LOAD
`define LOAD 5'b00011
`endif

module hazard_forwarding_unit #(
   parameter int DATA_SIZE    = 32,
   parameter int FWD_STAGES   = 2,
   parameter int LOAD_LATENCY = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_freeze,
   input  logic                            i_rd_valid,
   input  logic                            i_rd_use1,
   input  logic                            i_rd_use2,
   input  logic [15:0]                     i_rd_instr,
   input  logic [16*FWD_STAGES-1:0]        i_stage_instr,
   input  logic [FWD_STAGES-1:0]           i_stage_valid,
   input  logic [FWD_STAGES-1:0]           i_stage_wr_en,
   input  logic [DATA_SIZE*FWD_STAGES-1:0] i_stage_result,
   input  logic [DATA_SIZE-1:0]            i_operand1,
   input  logic [DATA_SIZE-1:0]            i_operand2,
   output logic [DATA_SIZE-1:0]            o_operand1,
   output logic [DATA_SIZE-1:0]            o_operand2,
   output logic                            o_stall,
   output logic                            o_bubble,
   output logic [15:0]                     o_stall_cnt,
   output logic [15:0]                     o_fwd_cnt,
   output logic                            o_dbg_state
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;
   localparam logic [1:0] CNT_LOAD = 2'(LOAD_LATENCY - 1);

   if (FWD_STAGES < 2 || FWD_STAGES > 4 || LOAD_LATENCY < 1 || LOAD_LATENCY > 3 ||
       FWD_STAGES <= LOAD_LATENCY) begin : g_bad_cfg
      $error("hazard_forwarding_unit: illegal FWD_STAGES/LOAD_LATENCY combination");
   end

   logic [2:0]            src1, src2;
   logic [FWD_STAGES-1:0] hit1, hit2;
   logic                  detect;
   logic [0:0]            state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  stall;
   logic                  unused_rd;

   assign src1      = i_rd_instr[7:5];
   assign src2      = i_rd_instr[4:2];
   assign unused_rd = ^{i_rd_instr[15:8], i_rd_instr[1:0]};

   // A LOAD is not a write source until it reaches stage LOAD_LATENCY.
   for (genvar k = 0; k < FWD_STAGES; k++) begin : g_stage
      localparam bit EARLY = (k < LOAD_LATENCY);
      logic [4:0] opc;
      logic [2:0] dst;
      logic       wr_src;
      logic       unused_lo;
      assign opc       = i_stage_instr[16*k+11 +: 5];
      assign dst       = i_stage_instr[16*k+8 +: 3];
      assign unused_lo = ^i_stage_instr[16*k +: 8];
      assign wr_src    = i_stage_valid[k] && i_stage_wr_en[k] && !(opc == `LOAD && EARLY);
      assign hit1[k]   = wr_src && (dst == src1);
      assign hit2[k]   = wr_src && (dst == src2);
   end

   // Scan from the oldest stage down so the youngest matching stage wins.
   always_comb begin
      o_operand1 = i_operand1;
      o_operand2 = i_operand2;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (i_rd_use1 && hit1[k]) o_operand1 = i_stage_result[DATA_SIZE*k +: DATA_SIZE];
         if (i_rd_use2 && hit2[k]) o_operand2 = i_stage_result[DATA_SIZE*k +: DATA_SIZE];
      end
   end

   assign detect = i_rd_valid && i_stage_valid[0] && i_stage_wr_en[0] &&
                   (i_stage_instr[15:11] == `LOAD) &&
                   ((i_rd_use1 && i_stage_instr[10:8] == src1) ||
                    (i_rd_use2 && i_stage_instr[10:8] == src2));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!i_freeze) begin
         case (state_q)
            ST_IDLE: begin
               if (detect && (LOAD_LATENCY > 1)) begin
                  state_d = ST_STALL;
                  cnt_d   = CNT_LOAD;
               end
            end
            ST_STALL: begin
               if (cnt_q <= 2'd1) begin
                  state_d = ST_IDLE;
                  cnt_d   = 2'd0;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Gated by reset so a held reset masks a combinational load-use hit.
   assign stall       = i_rst_n && (detect || state_q == ST_STALL);
   assign o_stall     = stall;
   assign o_bubble    = stall;
   assign o_dbg_state = state_q;

`ifdef HAZARD_STATS_EN
   logic        fwd_any;
   logic [15:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

   assign fwd_any = (i_rd_use1 && |hit1) || (i_rd_use2 && |hit2);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (!stall && fwd_any && fwd_cnt_q != 16'hFFFF) fwd_cnt_d = fwd_cnt_q + 16'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= 16'd0;
         fwd_cnt_q   <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_fwd_cnt   = fwd_cnt_q;
`else
   assign o_stall_cnt = 16'd0;
   assign o_fwd_cnt   = 16'd0;
`endif

endmodule
